// File: rtl/xarb_wrr_if.sv
// xarb_wrr_if: requester-side bundle of the weighted round-robin arbiter.
//
//   en      downstream accept; a beat transfers when en and |gnt are both 1
//   req     per-requester request, held for the whole packet
//   last    per-requester end-of-packet marker, qualified by its grant
//   weight  packed packet quanta, requester i at weight[WW*i +: WW]
//   gnt     one-hot grant (zero when nothing is granted)
//   gnt_id  binary index of the asserted gnt bit, 0 when gnt is 0
//   busy    high while a multi-beat packet holds the lock
//
// master: the requester/port side.  slave: the arbiter.
interface xarb_wrr_if #(
    parameter int N  = 8,
    parameter int WW = 4
);
    localparam int IW = $clog2(N);

    logic            en;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   gnt_id;
    logic            busy;

    modport master (
        output en, req, last, weight,
        input  gnt, gnt_id, busy
    );

    modport slave (
        input  en, req, last, weight,
        output gnt, gnt_id, busy
    );
endinterface

// File: rtl/xarb_wrr.sv
// xarb_wrr: weighted round-robin arbiter with packet lock.
//
// N requesters compete for one output. Each winner may send up to its
// programmed weight of consecutive packets before priority rotates past it.
// A multi-beat packet keeps the grant from its first beat through its last
// beat; other requesters are ignored while the lock is held.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous, active-low reset
//   bus   xarb_wrr_if slave modport (en/req/last/weight in, gnt/gnt_id/busy out)
//
// gnt and gnt_id are combinational from req, en and the current state;
// last only influences the next state. busy is the registered lock flag.
module xarb_wrr #(
    parameter int N  = 8,
    parameter int WW = 4
) (
    input  logic    clk,
    input  logic    rstn,
    xarb_wrr_if.slave bus
);
    localparam int IW = $clog2(N);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] owner, owner_n;
    logic [WW-1:0] cnt, cnt_n;

    logic [WW-1:0] wt [N];
    logic [IW-1:0] win;
    logic [IW-1:0] cur_w;
    logic [WW-1:0] fresh;
    logic [WW-1:0] credit;
    logic [WW-1:0] credit_left;
    logic          grant_ok;
    logic          beat;
    logic [N-1:0]  gnt_oh;

    // Unpack the weight bus so the winner's quantum can be indexed directly.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            wt[i] = bus.weight[WW*i +: WW];
        end
    end

    // Rotating priority search starting at ptr. Scanning from the farthest
    // offset down lets the nearest requester overwrite, so no early exit is
    // needed.
    always_comb begin
        win = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req[(int'(ptr) + k) % N]) begin
                win = IW'((int'(ptr) + k) % N);
            end
        end
    end

    // A weight of 0 is treated as a quantum of 1.
    assign fresh = (wt[win] == '0) ? WW'(1) : wt[win];

    // Remaining credit is only reused when the pointer's own requester wins
    // again; any other winner takes a fresh load, so skipped requesters lose
    // their turn.
    always_comb begin
        if (state == ST_LOCKED) begin
            cur_w    = owner;
            credit   = cnt;
            grant_ok = bus.en && bus.req[owner];
        end else begin
            cur_w    = win;
            credit   = (win == ptr && cnt != '0) ? cnt : fresh;
            grant_ok = bus.en && (|bus.req);
        end
    end

    assign credit_left = credit - 1'b1;
    assign beat        = grant_ok;

    always_comb begin
        gnt_oh        = '0;
        gnt_oh[cur_w] = grant_ok;
    end

    assign bus.gnt    = gnt_oh;
    assign bus.gnt_id = grant_ok ? cur_w : '0;
    assign bus.busy   = (state == ST_LOCKED);

    // Next-state logic. A locked non-last beat changes nothing; the packet
    // end update is shared between single-beat packets and locked last beats.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        if (beat) begin
            if (bus.last[cur_w]) begin
                state_n = ST_IDLE;
                if (credit_left == '0) begin
                    ptr_n = (cur_w == IW'(N - 1)) ? '0 : cur_w + 1'b1;
                    cnt_n = '0;
                end else begin
                    ptr_n = cur_w;
                    cnt_n = credit_left;
                end
            end else if (state == ST_IDLE) begin
                state_n = ST_LOCKED;
                owner_n = cur_w;
                ptr_n   = cur_w;
                cnt_n   = credit;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            cnt   <= cnt_n;
        end
    end

    // Simulation-only: at most one grant bit may be set.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(bus.gnt));

endmodule

// File: tb/tb_xarb_wrr.sv
// tb_xarb_wrr: self-checking bench for xarb_wrr with N=4, WW=4.
//
// A table of per-cycle vectors (inputs plus expected gnt/gnt_id/busy) is
// built up front. Each vector is driven just after a rising edge, its
// expected outputs are pushed to a scoreboard queue, and on the following
// falling edge the entry is popped and compared against the DUT. A vector
// may request a reset pulse before it is driven; busy is checked low while
// reset is asserted.
module tb_xarb_wrr;
    localparam int N  = 4;
    localparam int WW = 4;

    logic clk;
    logic rstn;

    xarb_wrr_if #(.N(N), .WW(WW)) bus ();

    xarb_wrr #(.N(N), .WW(WW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          do_rst;
        logic        en;
        logic [15:0] weight;
        logic [3:0]  req;
        logic [3:0]  last;
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic        busy;
    } vec_t;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input string tag, input bit do_rst,
                                input logic en, input logic [15:0] weight,
                                input logic [3:0] req, input logic [3:0] last,
                                input logic [3:0] gnt, input logic [1:0] id,
                                input logic busy);
        vecs.push_back('{tag, do_rst, en, weight, req, last, gnt, id, busy});
    endfunction

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        if (v.do_rst) begin
            rstn = 1'b0;
            #1;
            check($sformatf("%s[%0d].busy_in_reset", v.tag, idx),
                  32'(bus.busy), 32'd0);
            rstn = 1'b1;
        end
        bus.en     = v.en;
        bus.weight = v.weight;
        bus.req    = v.req;
        bus.last   = v.last;
        sb.push_back('{v.tag, v.gnt, v.id, v.busy});
        @(negedge clk);
        if (sb.size() == 0) begin
            check($sformatf("%s[%0d].scoreboard_empty", v.tag, idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s[%0d].gnt", e.tag, idx),    32'(bus.gnt),    32'(e.gnt));
            check($sformatf("%s[%0d].gnt_id", e.tag, idx), 32'(bus.gnt_id), 32'(e.id));
            check($sformatf("%s[%0d].busy", e.tag, idx),   32'(bus.busy),   32'(e.busy));
        end
    endtask

    initial begin
        rstn       = 1'b0;
        bus.en     = 1'b0;
        bus.req    = '0;
        bus.last   = '0;
        bus.weight = '0;

        // Round-robin rotation, all weights 1, single-beat packets.
        add("rr", 1, 1, 16'h1111, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);
        add("rr", 0, 1, 16'h1111, 4'b1111, 4'b1111, 4'b0010, 2'd1, 0);
        add("rr", 0, 1, 16'h1111, 4'b1111, 4'b1111, 4'b0100, 2'd2, 0);
        add("rr", 0, 1, 16'h1111, 4'b1111, 4'b1111, 4'b1000, 2'd3, 0);
        add("rr", 0, 1, 16'h1111, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);

        // Weighted share: requester 3 has a quantum of 3.
        add("wrr", 1, 1, 16'h3111, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);
        add("wrr", 0, 1, 16'h3111, 4'b1111, 4'b1111, 4'b0010, 2'd1, 0);
        add("wrr", 0, 1, 16'h3111, 4'b1111, 4'b1111, 4'b0100, 2'd2, 0);
        add("wrr", 0, 1, 16'h3111, 4'b1111, 4'b1111, 4'b1000, 2'd3, 0);
        add("wrr", 0, 1, 16'h3111, 4'b1111, 4'b1111, 4'b1000, 2'd3, 0);
        add("wrr", 0, 1, 16'h3111, 4'b1111, 4'b1111, 4'b1000, 2'd3, 0);
        add("wrr", 0, 1, 16'h3111, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);

        // Packet lock: 3-beat packet from requester 0, stalled once by en=0.
        add("lock", 1, 1, 16'h1111, 4'b0011, 4'b0000, 4'b0001, 2'd0, 0);
        add("lock", 0, 0, 16'h1111, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1);
        add("lock", 0, 1, 16'h1111, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1);
        add("lock", 0, 1, 16'h1111, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1);
        add("lock", 0, 1, 16'h1111, 4'b0011, 4'b0000, 4'b0010, 2'd1, 0);

        // Owner drops req mid-packet: lock held, nobody else granted.
        add("drop", 1, 1, 16'h1111, 4'b0011, 4'b0000, 4'b0001, 2'd0, 0);
        add("drop", 0, 1, 16'h1111, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1);
        add("drop", 0, 1, 16'h1111, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1);
        add("drop", 0, 1, 16'h1111, 4'b0011, 4'b0000, 4'b0010, 2'd1, 0);

        // Skip with fresh credit: leave ptr=2, cnt=2, then only 1 and 3 ask.
        add("skip", 1, 1, 16'h2311, 4'b0100, 4'b0100, 4'b0100, 2'd2, 0);
        add("skip", 0, 1, 16'h2311, 4'b1010, 4'b1010, 4'b1000, 2'd3, 0);
        add("skip", 0, 1, 16'h2311, 4'b1010, 4'b1010, 4'b1000, 2'd3, 0);
        add("skip", 0, 1, 16'h2311, 4'b1010, 4'b1010, 4'b0010, 2'd1, 0);

        // Reset mid-packet while locked on requester 2.
        add("rst", 1, 1, 16'h1111, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        add("rst", 0, 1, 16'h1111, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
        add("rst", 1, 1, 16'h1111, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);
        add("rst", 0, 1, 16'h1111, 4'b1111, 4'b1111, 4'b0010, 2'd1, 0);

        // Weight 0 behaves as a quantum of 1.
        add("w0", 1, 1, 16'h1110, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);
        add("w0", 0, 1, 16'h1110, 4'b1111, 4'b1111, 4'b0010, 2'd1, 0);
        add("w0", 0, 1, 16'h1110, 4'b1111, 4'b1111, 4'b0100, 2'd2, 0);
        add("w0", 0, 1, 16'h1110, 4'b1111, 4'b1111, 4'b1000, 2'd3, 0);
        add("w0", 0, 1, 16'h1110, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);
        add("w0", 0, 1, 16'h1110, 4'b1111, 4'b1111, 4'b0010, 2'd1, 0);

        // No requests: no grant, id 0.
        add("noreq", 1, 1, 16'h1111, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        add("noreq", 0, 1, 16'h1111, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0);

        // en=0 for 5 cycles mid-quantum of requester 1 (weight 3): afterwards
        // requester 1 still owns exactly the two remaining packets.
        add("en0", 1, 1, 16'h1131, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);
        add("en0", 0, 1, 16'h1131, 4'b1111, 4'b1111, 4'b0010, 2'd1, 0);
        for (int i = 0; i < 5; i++) begin
            add("en0", 0, 0, 16'h1131, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0);
        end
        add("en0", 0, 1, 16'h1131, 4'b1111, 4'b1111, 4'b0010, 2'd1, 0);
        add("en0", 0, 1, 16'h1131, 4'b1111, 4'b1111, 4'b0010, 2'd1, 0);
        add("en0", 0, 1, 16'h1131, 4'b1111, 4'b1111, 4'b0100, 2'd2, 0);

        // Weight is sampled only on a fresh load: requester 3 loads 3, then
        // its weight changes to 1 while the remaining credit still applies.
        add("wsamp", 1, 1, 16'h3111, 4'b1000, 4'b1000, 4'b1000, 2'd3, 0);
        add("wsamp", 0, 1, 16'h1111, 4'b1001, 4'b1001, 4'b1000, 2'd3, 0);
        add("wsamp", 0, 1, 16'h1111, 4'b1001, 4'b1001, 4'b1000, 2'd3, 0);
        add("wsamp", 0, 1, 16'h1111, 4'b1001, 4'b1001, 4'b0001, 2'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        if (sb.size() != 0) begin
            check("scoreboard_drained", 32'(sb.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
